axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
Round-robin write-channel arbiter that shares one AXI slave write port (AW/W/B) between NM AXI masters. It grants one master at a time and holds the grant for the whole transaction: AW handshake, all W beats, then B handshake. It sits between the masters and a slave such as axi_slave_2. It regenerates WLAST from AWLEN and flags masters whose WLAST disagrees.

Parameters:
NM, 2, number of masters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8, ASIZE = $clog2(DATA_W/8)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous reset, active-high
m_awaddr/m_awlen/m_awsize/m_awburst  in  NM*ADDR_W/NM*8/NM*ASIZE/NM*2  master AW payload; master i occupies slice i
m_awvalid  in  NM  per-master AW valid
m_awready  out  NM  per-master AW ready
m_wdata/m_wstrb/m_wlast  in  NM*DATA_W/NM*STRB_W/NM  master W payload
m_wvalid  in  NM  per-master W valid
m_wready  out  NM  per-master W ready
m_bresp  out  NM*2  per-master B response
m_bvalid  out  NM  per-master B valid
m_bready  in  NM  per-master B ready
s_awaddr/s_awlen/s_awsize/s_awburst  out  ADDR_W/8/ASIZE/2  slave AW payload
s_awvalid  out  1  slave AW valid;  s_awready  in  1
s_wdata/s_wstrb/s_wlast  out  DATA_W/STRB_W/1  slave W payload
s_wvalid  out  1  slave W valid;  s_wready  in  1
s_bresp  in  2  slave B response;  s_bvalid  in  1;  s_bready  out  1
grant  out  $clog2(NM)  index of the current or last granted master
busy  out  1  high in any state other than IDLE
err_wlast  out  NM  sticky per-master WLAST-mismatch flag

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any m_awvalid is set, register grant as the first requester searching upward (with wrap) from last_grant+1, latch awlen into len_q, clear beat_cnt, then go to ADDR. No slave signal is asserted in IDLE. Min latency m_awvalid to s_awvalid is 1 cycle.
- ADDR: s_aw* = m_aw*[grant], s_awvalid = m_awvalid[grant], m_awready[grant] = s_awready. On handshake go to DATA.
- DATA: s_wdata/s_wstrb = m_w*[grant], s_wvalid = m_wvalid[grant], m_wready[grant] = s_wready.
- s_wlast = (beat_cnt == len_q); the master's wlast is not forwarded.
- Each W handshake increments beat_cnt (8-bit).
- On the handshake with beat_cnt == len_q, go to RESP.
- If m_wlast[grant] != (beat_cnt == len_q) on any W handshake, set err_wlast[grant]. It stays set until reset and has no effect on sequencing.
- RESP: m_bvalid[grant] = s_bvalid, m_bresp[grant] = s_bresp, s_bready = m_bready[grant]. On B handshake set last_grant = grant and go to IDLE. The earliest next grant is the following cycle.
- Non-granted masters always see awready = 0, wready = 0, bvalid = 0, bresp = 0.
- W valid from a master before its AW is granted is stalled (wready = 0); it is never forwarded.
- Valid/payload muxes are combinational from state and grant; ready paths are combinational pass-through. No buffering, no outstanding transactions.
- Reset (asynchronous, any state, including mid-burst): state = IDLE, grant = 0, last_grant = NM-1 (master 0 has first priority), len_q = 0, beat_cnt = 0, err_wlast = 0.
- Consequently, during reset all valid/ready outputs = 0, busy = 0, and payload outputs = 0.
- awlen = 0 is a single-beat burst; awlen = 255 is 256 beats, and beat_cnt must not wrap before its last beat.

Test Plan:
- M0 only, awaddr=0x100, awlen=3, slave always ready -> s_awvalid 1 cycle after request; 4 W beats with s_wlast on beat 4 only; m_bvalid[0] on bvalid; busy drops after B.
- M0 and M1 request in the same cycle repeatedly (awlen=0) -> grant sequence 0,1,0,1; M1 sees awready=0 while M0 is granted.
- M1 sends wlast on beat 2 of an awlen=3 burst -> err_wlast = 2'b10; s_wlast still on beat 4; transaction completes.
- Slave holds s_bvalid=1 with m_bready[0]=0 for 5 cycles -> FSM stays in RESP, grant stable, M1 request pending until B handshake.
- areset pulsed after beat 2 of 4 -> all outputs 0 immediately; after release, the next simultaneous request grants M0.
- awlen=255 from M1 -> exactly 256 W beats forwarded, s_wlast only on beat 256, no err_wlast.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write slave (AW/W/B) among NM masters.
// The grant is held for a whole transaction; WLAST is regenerated from AWLEN.
module axi_wr_arbiter #(
    parameter int NM     = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int ASIZE  = $clog2(DATA_W / 8),
    localparam int GW     = $clog2(NM)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NM*ADDR_W-1:0] m_awaddr,
    input  logic [NM*8-1:0]      m_awlen,
    input  logic [NM*ASIZE-1:0]  m_awsize,
    input  logic [NM*2-1:0]      m_awburst,
    input  logic [NM-1:0]        m_awvalid,
    output logic [NM-1:0]        m_awready,
    input  logic [NM*DATA_W-1:0] m_wdata,
    input  logic [NM*STRB_W-1:0] m_wstrb,
    input  logic [NM-1:0]        m_wlast,
    input  logic [NM-1:0]        m_wvalid,
    output logic [NM-1:0]        m_wready,
    output logic [NM*2-1:0]      m_bresp,
    output logic [NM-1:0]        m_bvalid,
    input  logic [NM-1:0]        m_bready,
    output logic [ADDR_W-1:0]    s_awaddr,
    output logic [7:0]           s_awlen,
    output logic [ASIZE-1:0]     s_awsize,
    output logic [1:0]           s_awburst,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [DATA_W-1:0]    s_wdata,
    output logic [STRB_W-1:0]    s_wstrb,
    output logic                 s_wlast,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    input  logic [1:0]           s_bresp,
    input  logic                 s_bvalid,
    output logic                 s_bready,
    output logic [GW-1:0]        grant,
    output logic                 busy,
    output logic [NM-1:0]        err_wlast
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

    state_t        state;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant;
    logic [7:0]    len_q;
    logic [7:0]    beat_cnt;

    int   gi;
    int   ng;
    int   idx;
    logic found;
    logic last_beat;

    assign gi        = int'(grant_q);
    assign last_beat = (beat_cnt == len_q);
    assign grant     = grant_q;
    assign busy      = (state != StIdle);

    // First requester searching upward from last_grant+1, wrapping around.
    always_comb begin
        ng    = 0;
        idx   = 0;
        found = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last_grant) + k) % NM;
            if (!found && m_awvalid[idx]) begin
                ng    = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awburst = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        case (state)
            StAddr: begin
                s_awaddr      = m_awaddr[gi*ADDR_W +: ADDR_W];
                s_awlen       = m_awlen[gi*8 +: 8];
                s_awsize      = m_awsize[gi*ASIZE +: ASIZE];
                s_awburst     = m_awburst[gi*2 +: 2];
                s_awvalid     = m_awvalid[gi];
                m_awready[gi] = s_awready;
            end
            StData: begin
                s_wdata      = m_wdata[gi*DATA_W +: DATA_W];
                s_wstrb      = m_wstrb[gi*STRB_W +: STRB_W];
                s_wlast      = last_beat;
                s_wvalid     = m_wvalid[gi];
                m_wready[gi] = s_wready;
            end
            StResp: begin
                m_bvalid[gi]         = s_bvalid;
                m_bresp[gi*2 +: 2]   = s_bresp;
                s_bready             = m_bready[gi];
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= StIdle;
            grant_q    <= '0;
            last_grant <= GW'(NM - 1);
            len_q      <= '0;
            beat_cnt   <= '0;
            err_wlast  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|m_awvalid) begin
                        grant_q  <= GW'(ng);
                        len_q    <= m_awlen[ng*8 +: 8];
                        beat_cnt <= '0;
                        state    <= StAddr;
                    end
                end
                StAddr: begin
                    if (m_awvalid[gi] && s_awready) state <= StData;
                end
                StData: begin
                    if (m_wvalid[gi] && s_wready) begin
                        if (m_wlast[gi] != last_beat) err_wlast[gi] <= 1'b1;
                        // Hold the counter on the final beat so 256-beat bursts never wrap.
                        if (last_beat) state <= StResp;
                        else           beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                StResp: begin
                    if (s_bvalid && m_bready[gi]) begin
                        last_grant <= grant_q;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter with two masters.
module tb_axi_wr_arbiter;
    localparam int NM = 2, ADDR_W = 32, DATA_W = 32, STRB_W = 4, ASIZE = 2;

    logic aclk = 1'b0;
    logic areset;
    logic [NM*ADDR_W-1:0] m_awaddr;
    logic [NM*8-1:0]      m_awlen;
    logic [NM*ASIZE-1:0]  m_awsize;
    logic [NM*2-1:0]      m_awburst;
    logic [NM-1:0]        m_awvalid, m_awready;
    logic [NM*DATA_W-1:0] m_wdata;
    logic [NM*STRB_W-1:0] m_wstrb;
    logic [NM-1:0]        m_wlast, m_wvalid, m_wready;
    logic [NM*2-1:0]      m_bresp;
    logic [NM-1:0]        m_bvalid, m_bready;
    logic [ADDR_W-1:0]    s_awaddr;
    logic [7:0]           s_awlen;
    logic [ASIZE-1:0]     s_awsize;
    logic [1:0]           s_awburst;
    logic                 s_awvalid, s_awready;
    logic [DATA_W-1:0]    s_wdata;
    logic [STRB_W-1:0]    s_wstrb;
    logic                 s_wlast, s_wvalid, s_wready;
    logic [1:0]           s_bresp;
    logic                 s_bvalid, s_bready;
    logic [0:0]           grant;
    logic                 busy;
    logic [NM-1:0]        err_wlast;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi_wr_arbiter #(.NM(NM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .areset(areset),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy), .err_wlast(err_wlast)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_bresp = 2'b00; s_bvalid = 1'b0;
    endtask

    task automatic pulse_reset;
        areset = 1'b1;
        #3;
        areset = 1'b0;
        tick();
    endtask

    // One transaction from master m; master drives its own wlast on beat wl_beat.
    task automatic burst(input int m, input int len, input int wl_beat, input logic [31:0] addr);
        logic [DATA_W-1:0] wd;
        m_awaddr[m*ADDR_W +: ADDR_W] = addr;
        m_awlen[m*8 +: 8]            = 8'(len);
        m_awsize[m*ASIZE +: ASIZE]   = 2'd2;
        m_awburst[m*2 +: 2]          = 2'b01;
        m_awvalid                    = NM'(1 << m);
        #1;
        checks++;
        if ({s_awvalid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_aw m%0d: awvalid,busy=%b want 00", m, {s_awvalid, busy});
        end
        tick();
        checks++;
        if ({s_awvalid, busy, grant, m_awready} !== {2'b11, 1'(m), NM'(1 << m)} ||
            s_awaddr !== addr || s_awlen !== 8'(len) || s_awsize !== 2'd2 || s_awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw_fwd m%0d: v=%b g=%0d rdy=%b addr=%h len=%0d want addr=%h len=%0d",
                     m, s_awvalid, grant, m_awready, s_awaddr, s_awlen, addr, len);
        end
        tick();
        m_awvalid = '0;
        for (int b = 0; b <= len; b++) begin
            wd = 32'hD000_0000 | (32'(m) << 16) | 32'(b);
            m_wdata[m*DATA_W +: DATA_W] = wd;
            m_wstrb[m*STRB_W +: STRB_W] = 4'hF;
            m_wlast  = NM'((b == wl_beat) ? (1 << m) : 0);
            m_wvalid = NM'(1 << m);
            #1;
            checks++;
            if ({s_wvalid, s_wlast, m_wready} !== {1'b1, (b == len), NM'(1 << m)} ||
                s_wdata !== wd || s_wstrb !== 4'hF) begin
                errors++;
                $display("FAIL w_beat m%0d b%0d: v=%b last=%b rdy=%b data=%h want last=%b data=%h",
                         m, b, s_wvalid, s_wlast, m_wready, s_wdata, (b == len), wd);
            end
            tick();
        end
        m_wvalid = '0;
        m_wlast  = '0;
        s_bvalid = 1'b1;
        s_bresp  = 2'b01;
        m_bready = NM'(1 << m);
        #1;
        checks++;
        if ({m_bvalid, s_bready, m_bresp[m*2 +: 2], s_wvalid} !== {NM'(1 << m), 1'b1, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL b_fwd m%0d: bvalid=%b bready=%b bresp=%b want bvalid=%b bresp=01",
                     m, m_bvalid, s_bready, m_bresp[m*2 +: 2], NM'(1 << m));
        end
        tick();
        s_bvalid = 1'b0;
        m_bready = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop m%0d: busy=%b want 0", m, busy);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        areset = 1'b1;
        #2;
        checks++;
        if ({busy, grant, err_wlast, s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b grant=%b err=%b awv=%b wv=%b want all 0",
                     busy, grant, err_wlast, s_awvalid, s_wvalid);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        burst(0, 3, 3, 32'h100);
        checks++;
        if (err_wlast !== 2'b00) begin
            errors++;
            $display("FAIL single_err: err_wlast=%b want 00", err_wlast);
        end
    endtask

    task automatic test_round_robin;
        int exp;
        pulse_reset();
        m_awaddr  = {32'h2000, 32'h1000};
        m_awlen   = '0;
        m_awvalid = 2'b11;
        s_bvalid  = 1'b1;
        m_bready  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            tick();
            checks++;
            if ({grant, m_awready} !== {1'(exp), NM'(1 << exp)} ||
                s_awaddr !== (exp == 0 ? 32'h1000 : 32'h2000)) begin
                errors++;
                $display("FAIL rr_grant k%0d: grant=%0d awready=%b addr=%h want grant=%0d",
                         k, grant, m_awready, s_awaddr, exp);
            end
            tick();
            m_wvalid = NM'(1 << exp);
            m_wlast  = NM'(1 << exp);
            #1;
            checks++;
            if ({s_wlast, m_wready, m_bvalid} !== {1'b1, NM'(1 << exp), 2'b00}) begin
                errors++;
                $display("FAIL rr_data k%0d: wlast=%b wready=%b bvalid=%b", k, s_wlast, m_wready, m_bvalid);
            end
            tick();
            m_wvalid = '0;
            m_wlast  = '0;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_wlast_err;
        burst(1, 3, 1, 32'h300);
        checks++;
        if (err_wlast !== 2'b10) begin
            errors++;
            $display("FAIL wlast_err: err_wlast=%b want 10", err_wlast);
        end
    endtask

    task automatic test_b_stall;
        m_awlen   = '0;
        m_awvalid = 2'b01;
        tick();
        tick();
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        m_wlast   = 2'b11;
        m_wdata   = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        #1;
        checks++;
        if ({grant, m_wready} !== {1'b0, 2'b01} || s_wdata !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL w_stall_other: grant=%0d wready=%b data=%h want 0 01 aaaaaaaa",
                     grant, m_wready, s_wdata);
        end
        tick();
        m_wvalid = '0;
        m_wlast  = '0;
        s_bvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({busy, grant, m_bvalid, s_bready, m_awready} !== {2'b10, 2'b01, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL b_stall c%0d: busy=%b grant=%0d bvalid=%b bready=%b awready=%b",
                         c, busy, grant, m_bvalid, s_bready, m_awready);
            end
            tick();
        end
        m_bready = 2'b01;
        tick();
        s_bvalid  = 1'b0;
        m_bready  = '0;
        m_awvalid = 2'b10;
        tick();
        checks++;
        if ({grant, m_awready} !== {1'b1, 2'b10}) begin
            errors++;
            $display("FAIL b_stall_next: grant=%0d awready=%b want 1 10", grant, m_awready);
        end
        tick();
        m_awvalid = '0;
        m_wvalid  = 2'b10;
        m_wlast   = 2'b10;
        tick();
        clear_inputs();
        s_bvalid = 1'b1;
        m_bready = 2'b10;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_midburst;
        m_awlen   = {8'd0, 8'd3};
        m_awaddr  = {32'h0, 32'h4000};
        m_awvalid = 2'b01;
        tick();
        tick();
        m_awvalid = '0;
        m_wvalid  = 2'b01;
        m_wdata   = {32'h0, 32'h1234_5678};
        tick();
        tick();
        areset = 1'b1;
        #1;
        checks++;
        if ({busy, grant, s_wvalid, m_wready, err_wlast} !== '0 || s_wdata !== '0 || s_awaddr !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b grant=%0d wvalid=%b wready=%b err=%b wdata=%h want 0",
                     busy, grant, s_wvalid, m_wready, err_wlast, s_wdata);
        end
        m_wvalid  = '0;
        m_awlen   = '0;
        m_awvalid = 2'b11;
        areset    = 1'b0;
        tick();
        checks++;
        if ({grant, s_awvalid, m_awready} !== {1'b0, 1'b1, 2'b01}) begin
            errors++;
            $display("FAIL reset_regrant: grant=%0d awvalid=%b awready=%b want 0 1 01",
                     grant, s_awvalid, m_awready);
        end
        tick();
        m_awvalid = '0;
        m_wvalid  = 2'b01;
        m_wlast   = 2'b01;
        tick();
        clear_inputs();
        s_bvalid = 1'b1;
        m_bready = 2'b01;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_long_burst;
        burst(1, 255, 255, 32'h8000);
        checks++;
        if (err_wlast !== 2'b00) begin
            errors++;
            $display("FAIL long_err: err_wlast=%b want 00", err_wlast);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wlast_err();
        test_b_stall();
        test_reset_midburst();
        test_long_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
